dmem_bus_bridge: RTL and testbench

//  Sits between the MEM stage's data-memory port and the external data bus.

---
 rtl/dmem_bus_bridge_if.sv | 23 ++
 rtl/dmem_bus_bridge.sv | 137 +++++++++++++
 tb/tb_dmem_bus_bridge.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_bridge_if.sv
// Data-bus side of the MEM-stage bridge: request channel (valid/ready) plus 1-cycle response strobe.
// master = bridge, slave = bus agent / memory.
interface dmem_bus_bridge_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_addr;
  logic        bus_we;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_be;
  logic        bus_rsp_valid;
  logic [63:0] bus_rsp_rdata;
  logic        bus_rsp_err;

  modport master (
    output bus_req_valid, bus_addr, bus_we, bus_wdata, bus_be,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_we, bus_wdata, bus_be,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Bridges the MEM stage's single-cycle load/store into a valid/ready bus request and waits for its response.
// Latency: 3 stall cycles minimum, result in the 4th; backpressure: stalls the pipeline until rsp or timeout.
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [63:0]          cpu_addr,
  input  logic [63:0]          cpu_wdata,
  input  logic [7:0]           cpu_be,
  output logic                 cpu_stall,
  output logic [63:0]          cpu_rdata,
  output logic                 cpu_err,
  dmem_bus_bridge_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;

  logic [63:0]       addr_q;
  logic [63:0]       wdata_q;
  logic [7:0]        be_q;
  logic              we_q;
  logic [63:0]       rdata_q;
  logic              err_q;

  assign cnt_inc = cnt_q + 1'b1;
  // Fires in the WAIT_RSP cycle whose count reaches the limit, giving exactly TIMEOUT_CYCLES wait cycles.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_LIM);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (cpu_req)                          state_d = REQ;
      REQ:      if (bus.bus_req_ready)                state_d = WAIT_RSP;
      WAIT_RSP: if (bus.bus_rsp_valid || timeout_hit) state_d = DONE;
      DONE:                                           state_d = IDLE;
      default:                                        state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cpu_stall         = 1'b0;
    cpu_err           = 1'b0;
    bus.bus_req_valid = 1'b0;
    unique case (state_q)
      // Gated by rst_n so the stall is dropped the moment reset asserts, even with cpu_req held.
      IDLE:     cpu_stall = cpu_req & rst_n;
      REQ: begin
        cpu_stall         = 1'b1;
        bus.bus_req_valid = 1'b1;
      end
      WAIT_RSP: cpu_stall = 1'b1;
      DONE:     cpu_err   = err_q;
      default:  cpu_stall = 1'b0;
    endcase
  end

  // Request capture, timeout counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            be_q    <= cpu_be;
            we_q    <= cpu_we;
          end
        end
        REQ: begin
          if (bus.bus_req_ready) begin
            cnt_q <= '0;
          end
        end
        WAIT_RSP: begin
          cnt_q <= cnt_inc;
          // A response in the timeout cycle still completes normally.
          if (bus.bus_rsp_valid) begin
            rdata_q <= we_q ? 64'd0 : bus.bus_rsp_rdata;
            err_q   <= bus.bus_rsp_err;
          end else if (timeout_hit) begin
            rdata_q <= 64'd0;
            err_q   <= 1'b1;
          end
        end
        DONE: begin
          err_q <= 1'b0;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  assign cpu_rdata     = rdata_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_be    = be_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge (TIMEOUT_CYCLES=4): drives inputs at posedge+1, samples at negedge.
module tb_dmem_bus_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [63:0] cpu_addr = '0;
  logic [63:0] cpu_wdata = '0;
  logic [7:0]  cpu_be = '0;
  logic        cpu_stall;
  logic [63:0] cpu_rdata;
  logic        cpu_err;

  always #5 clk = ~clk;

  dmem_bus_bridge_if bus ();

  dmem_bus_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_be    (cpu_be),
    .cpu_stall (cpu_stall),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .bus       (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One CPU access with a scripted bus agent. Entered and left at posedge+1.
  task automatic access(input string tag, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] be,
                        input int rdy_wait, input int rsp_wait, input logic rsp_en,
                        input logic rerr, input logic [63:0] rdat,
                        output int stalls, output logic [63:0] rd, output logic er,
                        output int nvalid);
    int vcnt;
    int wcnt;
    bit acc;
    bit acc_now;
    bit done;
    vcnt = 0; wcnt = 0; acc = 0; done = 0;
    stalls = 0; nvalid = 0; rd = '0; er = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      acc_now = 0;
      if (bus.bus_req_valid) begin
        if (vcnt >= rdy_wait) begin
          bus.bus_req_ready = 1'b1;
          acc_now = 1;
        end
        vcnt++;
      end
      if (acc) begin
        if (rsp_en && wcnt == rsp_wait) begin
          bus.bus_rsp_valid = 1'b1;
          bus.bus_rsp_rdata = rdat;
          bus.bus_rsp_err   = rerr;
        end
        wcnt++;
      end
      @(negedge clk);
      if (bus.bus_req_valid) begin
        nvalid++;
        check({tag, "_bus_addr"},  bus.bus_addr, addr);
        check({tag, "_bus_we"},    64'(bus.bus_we), 64'(we));
        check({tag, "_bus_wdata"}, bus.bus_wdata, wdata);
        check({tag, "_bus_be"},    64'(bus.bus_be), 64'(be));
      end
      if (cpu_stall) stalls++;
      else begin
        rd = cpu_rdata;
        er = cpu_err;
        done = 1;
      end
      @(posedge clk); #1;
      bus.bus_req_ready = 1'b0;
      bus.bus_rsp_valid = 1'b0;
      bus.bus_rsp_err   = 1'b0;
      if (acc_now) acc = 1;
    end
    check({tag, "_completed"}, 64'(done), 64'd1);
  endtask

  int          st;
  int          nv;
  logic [63:0] rd;
  logic        er;

  initial begin
    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b0;
    bus.bus_rsp_rdata = '0;
    bus.bus_rsp_err   = 1'b0;

    // Reset state
    #1;
    check("rst_stall", 64'(cpu_stall), 64'd0);
    check("rst_rdata", cpu_rdata, 64'd0);
    check("rst_err",   64'(cpu_err), 64'd0);
    check("rst_valid", 64'(bus.bus_req_valid), 64'd0);
    check("rst_addr",  bus.bus_addr, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic load, ready immediately, rsp in first wait cycle
    access("t1", 1'b0, 64'h1000, 64'd0, 8'hFF, 0, 0, 1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D, st, rd, er, nv);
    cpu_req = 1'b0;
    check("t1_stalls", 64'(st), 64'd3);
    check("t1_rdata",  rd, 64'hDEADBEEF_CAFEF00D);
    check("t1_err",    64'(er), 64'd0);
    check("t1_nvalid", 64'(nv), 64'd1);

    // 2: store held off by ready=0 for 5 cycles; rdata forced to zero
    access("t2", 1'b1, 64'h2008, 64'h11223344, 8'h0F, 5, 2, 1'b1, 1'b0, 64'hFFFF_FFFF, st, rd, er, nv);
    cpu_req = 1'b0;
    check("t2_stalls", 64'(st), 64'd10);
    check("t2_rdata",  rd, 64'd0);
    check("t2_err",    64'(er), 64'd0);
    check("t2_nvalid", 64'(nv), 64'd6);

    // 3: load with bus error; cpu_err is a single-cycle pulse, rdata holds afterwards
    access("t3", 1'b0, 64'h3000, 64'd0, 8'hFF, 0, 0, 1'b1, 1'b1, 64'h01234567_89ABCDEF, st, rd, er, nv);
    cpu_req = 1'b0;
    check("t3_stalls", 64'(st), 64'd3);
    check("t3_rdata",  rd, 64'h01234567_89ABCDEF);
    check("t3_err",    64'(er), 64'd1);
    @(negedge clk);
    check("t3_err_after",   64'(cpu_err), 64'd0);
    check("t3_rdata_hold",  cpu_rdata, 64'h01234567_89ABCDEF);
    @(posedge clk); #1;

    // 4: timeout after 4 wait cycles, then a stale response is ignored
    access("t4", 1'b0, 64'h4000, 64'd0, 8'hFF, 0, 0, 1'b0, 1'b0, 64'd0, st, rd, er, nv);
    cpu_req = 1'b0;
    check("t4_stalls", 64'(st), 64'd6);
    check("t4_rdata",  rd, 64'd0);
    check("t4_err",    64'(er), 64'd1);
    bus.bus_rsp_valid = 1'b1;
    bus.bus_rsp_rdata = 64'hBAD0_BAD0;
    bus.bus_rsp_err   = 1'b1;
    @(negedge clk);
    check("t4_stale_stall", 64'(cpu_stall), 64'd0);
    check("t4_stale_err",   64'(cpu_err), 64'd0);
    @(posedge clk); #1;
    bus.bus_rsp_valid = 1'b0;
    bus.bus_rsp_err   = 1'b0;
    @(negedge clk);
    check("t4_stale_rdata", cpu_rdata, 64'd0);
    check("t4_stale_valid", 64'(bus.bus_req_valid), 64'd0);
    @(posedge clk); #1;

    // 4b: response in the same cycle as the timeout wins
    access("t4b", 1'b0, 64'h4100, 64'd0, 8'hFF, 0, 3, 1'b1, 1'b0, 64'hA5A5_5A5A_A5A5_5A5A, st, rd, er, nv);
    cpu_req = 1'b0;
    check("t4b_stalls", 64'(st), 64'd6);
    check("t4b_rdata",  rd, 64'hA5A5_5A5A_A5A5_5A5A);
    check("t4b_err",    64'(er), 64'd0);

    // 5: back-to-back loads with cpu_req held high
    access("t5a", 1'b0, 64'h5000, 64'd0, 8'hFF, 0, 0, 1'b1, 1'b0, 64'h1111_2222_3333_4444, st, rd, er, nv);
    check("t5a_stalls", 64'(st), 64'd3);
    check("t5a_rdata",  rd, 64'h1111_2222_3333_4444);
    check("t5a_nvalid", 64'(nv), 64'd1);
    access("t5b", 1'b0, 64'h5008, 64'd0, 8'hFF, 0, 1, 1'b1, 1'b0, 64'h5555_6666_7777_8888, st, rd, er, nv);
    cpu_req = 1'b0;
    check("t5b_stalls", 64'(st), 64'd4);
    check("t5b_rdata",  rd, 64'h5555_6666_7777_8888);
    check("t5b_nvalid", 64'(nv), 64'd1);

    // 6: reset asserted during WAIT_RSP
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h6000; cpu_be = 8'hFF;
    @(posedge clk); #1;
    bus.bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.bus_req_ready = 1'b0;
    @(negedge clk);
    check("t6_in_wait_stall", 64'(cpu_stall), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_stall", 64'(cpu_stall), 64'd0);
    check("t6_rst_rdata", cpu_rdata, 64'd0);
    check("t6_rst_err",   64'(cpu_err), 64'd0);
    check("t6_rst_valid", 64'(bus.bus_req_valid), 64'd0);
    check("t6_rst_addr",  bus.bus_addr, 64'd0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.bus_rsp_valid = 1'b1;
    bus.bus_rsp_rdata = 64'hFFFF;
    bus.bus_rsp_err   = 1'b1;
    @(negedge clk);
    check("t6_stale_stall", 64'(cpu_stall), 64'd0);
    @(posedge clk); #1;
    bus.bus_rsp_valid = 1'b0;
    bus.bus_rsp_err   = 1'b0;
    @(negedge clk);
    check("t6_stale_rdata", cpu_rdata, 64'd0);
    check("t6_stale_err",   64'(cpu_err), 64'd0);
    @(posedge clk); #1;
    access("t6n", 1'b0, 64'h7000, 64'd0, 8'hFF, 0, 0, 1'b1, 1'b0, 64'hCAFE_0000_BEEF_0001, st, rd, er, nv);
    cpu_req = 1'b0;
    check("t6n_stalls", 64'(st), 64'd3);
    check("t6n_rdata",  rd, 64'hCAFE_0000_BEEF_0001);
    check("t6n_err",    64'(er), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
